// File: rtl/ahblite_master_arbiter_if.sv
// ----------------------------------------------------------------------------
// ahblite_master_arbiter_if
// Purpose : One AHB-Lite master-side signal bundle. The arbiter uses one
//           instance per requesting master and one for the shared bus.
// Signals : HADDR/HTRANS/HWRITE/HSIZE/HBURST/HPROT/HMASTLOCK/HWDATA travel
//           from the master towards the slave; HRDATA/HREADY/HRESP travel back.
// Modports: master - drives address/control/write data, receives response
//           slave  - receives address/control/write data, drives response
// ----------------------------------------------------------------------------
interface ahblite_master_arbiter_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahblite_master_arbiter.sv
// ----------------------------------------------------------------------------
// ahblite_master_arbiter
// Purpose : Two-master AHB-Lite arbiter (M0 = CPU, M1 = camera/DMA) sharing a
//           single AHB-Lite bus. The grant only moves at transfer boundaries
//           (owner IDLE, unlocked, HREADY high), parks back to DEFAULT_MASTER
//           after PARK_CYCLES idle cycles and flags a starving waiting master.
// Ports   : HCLK        bus clock
//           HRESETn     synchronous active-low reset
//           m0, m1      master ports (slave view): requests in, responses out
//           bus         shared bus (master view): muxed requests out,
//                       HREADY/HRESP/HRDATA from the slave mux in
//           HMASTER     current grant holder
//           ARB_STARVE  waiting master has waited >= STARVE_LIMIT cycles
// ----------------------------------------------------------------------------
module ahblite_master_arbiter #(
    parameter int DEFAULT_MASTER = 0,
    parameter int PARK_CYCLES    = 8,
    parameter int STARVE_LIMIT   = 64
) (
    input  logic                            HCLK,
    input  logic                            HRESETn,
    ahblite_master_arbiter_if.slave         m0,
    ahblite_master_arbiter_if.slave         m1,
    ahblite_master_arbiter_if.master        bus,
    output logic                            HMASTER,
    output logic                            ARB_STARVE
);

    localparam logic        DEF_GNT    = 1'(DEFAULT_MASTER);
    localparam logic [7:0]  PARK_MAX   = 8'(PARK_CYCLES - 1);
    localparam logic [15:0] STARVE_LIM = 16'(STARVE_LIMIT);
    localparam logic [1:0]  TRANS_IDLE = 2'b00;

    logic        gnt_q, gnt_d;
    logic [7:0]  park_cnt_q, park_cnt_d;
    logic [15:0] starve_cnt_q, starve_cnt_d;
    logic        arb_starve_q, arb_starve_d;

    logic [1:0]  owner_trans_s;
    logic        owner_lock_s;
    logic        req_other_s;
    logic        both_idle_s;
    logic        switch_pt_s;

    // Owner/waiter view of the two masters and the safe-switch qualifier.
    always_comb begin
        owner_trans_s = TRANS_IDLE;
        owner_lock_s  = 1'b0;
        req_other_s   = 1'b0;
        if (gnt_q == 1'b1) begin
            owner_trans_s = m1.HTRANS;
            owner_lock_s  = m1.HMASTLOCK;
            req_other_s   = m0.HTRANS[1];
        end else begin
            owner_trans_s = m0.HTRANS;
            owner_lock_s  = m0.HMASTLOCK;
            req_other_s   = m1.HTRANS[1];
        end
        both_idle_s = (m0.HTRANS == TRANS_IDLE) && (m1.HTRANS == TRANS_IDLE);
        // A boundary with no outstanding data phase for the owner: the old
        // owner cannot be left with a pending beat once the grant moves.
        switch_pt_s = bus.HREADY && (owner_trans_s == TRANS_IDLE) && !owner_lock_s;
    end

    // Next grant, park counter, starvation counter and starvation flag.
    always_comb begin
        gnt_d        = gnt_q;
        park_cnt_d   = 8'd0;
        starve_cnt_d = 16'd0;

        // A waiting request beats parking, so the idle owner always hands over.
        if (switch_pt_s && req_other_s) begin
            gnt_d = ~gnt_q;
        end else if (switch_pt_s && (park_cnt_q == PARK_MAX) && (gnt_q != DEF_GNT)) begin
            gnt_d = DEF_GNT;
        end else begin
            gnt_d = gnt_q;
        end

        if (gnt_d != gnt_q) begin
            park_cnt_d = 8'd0;
        end else if (bus.HREADY && both_idle_s && !owner_lock_s) begin
            if (park_cnt_q == PARK_MAX) begin
                park_cnt_d = park_cnt_q;
            end else begin
                park_cnt_d = park_cnt_q + 8'd1;
            end
        end else begin
            park_cnt_d = 8'd0;
        end

        if (req_other_s && !switch_pt_s) begin
            if (starve_cnt_q == 16'hFFFF) begin
                starve_cnt_d = starve_cnt_q;
            end else begin
                starve_cnt_d = starve_cnt_q + 16'd1;
            end
        end else begin
            starve_cnt_d = 16'd0;
        end

        // Flag reflects the counter value being loaded, so it rises together with it.
        arb_starve_d = (starve_cnt_d >= STARVE_LIM);
    end

    // Arbiter state registers with synchronous active-low reset.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            gnt_q        <= DEF_GNT;
            park_cnt_q   <= 8'd0;
            starve_cnt_q <= 16'd0;
            arb_starve_q <= 1'b0;
        end else begin
            gnt_q        <= gnt_d;
            park_cnt_q   <= park_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            arb_starve_q <= arb_starve_d;
        end
    end

    // Zero-latency bus and response muxing on the registered grant; the
    // non-owner is stalled with HREADY low so it keeps its request stable.
    always_comb begin
        bus.HADDR     = m0.HADDR;
        bus.HTRANS    = m0.HTRANS;
        bus.HWRITE    = m0.HWRITE;
        bus.HSIZE     = m0.HSIZE;
        bus.HBURST    = m0.HBURST;
        bus.HPROT     = m0.HPROT;
        bus.HMASTLOCK = m0.HMASTLOCK;
        bus.HWDATA    = m0.HWDATA;
        m0.HREADY     = 1'b0;
        m0.HRESP      = 1'b0;
        m1.HREADY     = 1'b0;
        m1.HRESP      = 1'b0;
        if (gnt_q == 1'b1) begin
            bus.HADDR     = m1.HADDR;
            bus.HTRANS    = m1.HTRANS;
            bus.HWRITE    = m1.HWRITE;
            bus.HSIZE     = m1.HSIZE;
            bus.HBURST    = m1.HBURST;
            bus.HPROT     = m1.HPROT;
            bus.HMASTLOCK = m1.HMASTLOCK;
            bus.HWDATA    = m1.HWDATA;
            m1.HREADY     = bus.HREADY;
            m1.HRESP      = bus.HRESP;
        end else begin
            m0.HREADY     = bus.HREADY;
            m0.HRESP      = bus.HRESP;
        end
        m0.HRDATA = bus.HRDATA;
        m1.HRDATA = bus.HRDATA;
    end

    assign HMASTER    = gnt_q;
    assign ARB_STARVE = arb_starve_q;

endmodule

// File: tb/tb_ahblite_master_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ahblite_master_arbiter
// Directed bench for ahblite_master_arbiter. A cycle-level model of the
// arbitration rules predicts grant, park and starvation state; a negedge
// process compares every DUT output against it, and the directed sequence
// adds literal expectations for the key scenarios.
// ----------------------------------------------------------------------------
module tb_ahblite_master_arbiter;
    localparam int DEF   = 0;
    localparam int PARK  = 8;
    localparam int LIMIT = 64;

    logic HCLK = 1'b0;
    logic HRESETn;
    logic HMASTER;
    logic ARB_STARVE;

    ahblite_master_arbiter_if m0_if ();
    ahblite_master_arbiter_if m1_if ();
    ahblite_master_arbiter_if bus_if ();

    ahblite_master_arbiter #(
        .DEFAULT_MASTER (DEF),
        .PARK_CYCLES    (PARK),
        .STARVE_LIMIT   (LIMIT)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .m0         (m0_if),
        .m1         (m1_if),
        .bus        (bus_if),
        .HMASTER    (HMASTER),
        .ARB_STARVE (ARB_STARVE)
    );

    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic mg;          // who holds the bus
    int   mpark;       // consecutive idle cycles seen
    int   mstarve;     // cycles the waiter has been refused
    logic mflag;
    logic mvalid = 1'b0;

    function automatic logic [1:0] trans_of(input logic who);
        return who ? m1_if.HTRANS : m0_if.HTRANS;
    endfunction

    function automatic logic lock_of(input logic who);
        return who ? m1_if.HMASTLOCK : m0_if.HMASTLOCK;
    endfunction

    function automatic logic boundary();
        return bus_if.HREADY && (trans_of(mg) == 2'd0) && !lock_of(mg);
    endfunction

    function automatic logic waiter_wants();
        return trans_of(~mg) >= 2'd2;   // NONSEQ or SEQ
    endfunction

    function automatic logic nxt_g();
        if (boundary() && waiter_wants()) return ~mg;
        if (boundary() && (mpark == PARK - 1) && (mg != 1'(DEF))) return 1'(DEF);
        return mg;
    endfunction

    function automatic int nxt_park();
        if (nxt_g() != mg) return 0;
        if (bus_if.HREADY && (m0_if.HTRANS == 2'd0) && (m1_if.HTRANS == 2'd0) && !lock_of(mg))
            return (mpark + 1 > PARK - 1) ? PARK - 1 : mpark + 1;
        return 0;
    endfunction

    function automatic int nxt_starve();
        if (waiter_wants() && !boundary())
            return (mstarve + 1 > 65535) ? 65535 : mstarve + 1;
        return 0;
    endfunction

    always @(posedge HCLK) begin
        if (!HRESETn) begin
            mg      <= 1'(DEF);
            mpark   <= 0;
            mstarve <= 0;
            mflag   <= 1'b0;
            mvalid  <= 1'b1;
        end else begin
            mg      <= nxt_g();
            mpark   <= nxt_park();
            mstarve <= nxt_starve();
            mflag   <= (nxt_starve() >= LIMIT);
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge HCLK) begin
        if (mvalid) begin
            chk("HMASTER",    HMASTER, mg);
            chk("ARB_STARVE", ARB_STARVE, mflag);
            chk("HADDR",      bus_if.HADDR,     mg ? m1_if.HADDR     : m0_if.HADDR);
            chk("HTRANS",     bus_if.HTRANS,    mg ? m1_if.HTRANS    : m0_if.HTRANS);
            chk("HWRITE",     bus_if.HWRITE,    mg ? m1_if.HWRITE    : m0_if.HWRITE);
            chk("HSIZE",      bus_if.HSIZE,     mg ? m1_if.HSIZE     : m0_if.HSIZE);
            chk("HBURST",     bus_if.HBURST,    mg ? m1_if.HBURST    : m0_if.HBURST);
            chk("HPROT",      bus_if.HPROT,     mg ? m1_if.HPROT     : m0_if.HPROT);
            chk("HMASTLOCK",  bus_if.HMASTLOCK, mg ? m1_if.HMASTLOCK : m0_if.HMASTLOCK);
            chk("HWDATA",     bus_if.HWDATA,    mg ? m1_if.HWDATA    : m0_if.HWDATA);
            chk("M0_HREADY",  m0_if.HREADY, mg ? 1'b0 : bus_if.HREADY);
            chk("M1_HREADY",  m1_if.HREADY, mg ? bus_if.HREADY : 1'b0);
            chk("M0_HRESP",   m0_if.HRESP,  mg ? 1'b0 : bus_if.HRESP);
            chk("M1_HRESP",   m1_if.HRESP,  mg ? bus_if.HRESP : 1'b0);
            chk("M0_HRDATA",  m0_if.HRDATA, bus_if.HRDATA);
            chk("M1_HRDATA",  m1_if.HRDATA, bus_if.HRDATA);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge HCLK);
        #1;
        bus_if.HRDATA = $urandom;
    endtask

    task automatic set_m(input int idx, input logic [1:0] tr, input logic [31:0] a, input logic lk);
        if (idx == 0) begin
            m0_if.HTRANS    = tr;
            m0_if.HADDR     = a;
            m0_if.HMASTLOCK = lk;
            m0_if.HWDATA    = a ^ 32'h5A5A_0000;
        end else begin
            m1_if.HTRANS    = tr;
            m1_if.HADDR     = a;
            m1_if.HMASTLOCK = lk;
            m1_if.HWDATA    = a ^ 32'h0000_A5A5;
        end
    endtask

    initial begin
        HRESETn          = 1'b0;
        m0_if.HWRITE     = 1'b1;
        m0_if.HSIZE      = 3'b010;
        m0_if.HBURST     = 3'b000;
        m0_if.HPROT      = 4'b0011;
        m1_if.HWRITE     = 1'b0;
        m1_if.HSIZE      = 3'b010;
        m1_if.HBURST     = 3'b011;
        m1_if.HPROT      = 4'b0001;
        set_m(0, 2'b00, 32'h1000_0000, 1'b0);
        set_m(1, 2'b00, 32'h4030_0000, 1'b0);
        bus_if.HREADY    = 1'b1;
        bus_if.HRESP     = 1'b0;
        bus_if.HRDATA    = 32'hA5A5_0001;
        cyc();
        cyc();

        // 1. reset state
        chk("rst_HMASTER",    HMASTER, 1'b0);
        chk("rst_M1_HREADY",  m1_if.HREADY, 1'b0);
        chk("rst_ARB_STARVE", ARB_STARVE, 1'b0);
        chk("rst_HADDR",      bus_if.HADDR, 32'h1000_0000);
        chk("rst_HWRITE",     bus_if.HWRITE, 1'b1);
        HRESETn = 1'b1;
        cyc();

        // 2. M1 request while M0 idles: one stall cycle, then on the bus
        set_m(1, 2'b10, 32'h4030_0000, 1'b0);
        #1;
        chk("req_M1_HREADY_wait", m1_if.HREADY, 1'b0);
        cyc();
        chk("sw_HMASTER", HMASTER, 1'b1);
        chk("sw_HADDR",   bus_if.HADDR, 32'h4030_0000);
        chk("sw_M1_HREADY", m1_if.HREADY, 1'b1);
        bus_if.HREADY = 1'b0;
        #1;
        chk("sw_M1_HREADY_low", m1_if.HREADY, 1'b0);
        bus_if.HREADY = 1'b1;

        // 3. INCR4 burst by M1 while M0 requests; handover only after IDLE
        set_m(0, 2'b10, 32'h1000_0010, 1'b0);
        cyc();
        chk("burst_hold0", HMASTER, 1'b1);
        set_m(1, 2'b11, 32'h4030_0004, 1'b0);
        bus_if.HREADY = 1'b0;
        cyc();
        chk("burst_hold_wait", HMASTER, 1'b1);
        bus_if.HREADY = 1'b1;
        cyc();
        set_m(1, 2'b11, 32'h4030_0008, 1'b0);
        cyc();
        set_m(1, 2'b11, 32'h4030_000C, 1'b0);
        cyc();
        chk("burst_hold_last", HMASTER, 1'b1);
        set_m(1, 2'b00, 32'h4030_000C, 1'b0);
        cyc();
        chk("burst_end_HMASTER", HMASTER, 1'b0);
        chk("burst_end_HADDR",   bus_if.HADDR, 32'h1000_0010);

        // 4. locked sequence by M0 holds the grant across an IDLE
        set_m(0, 2'b10, 32'h1000_0020, 1'b1);
        set_m(1, 2'b10, 32'h4030_0010, 1'b0);
        cyc();
        set_m(0, 2'b00, 32'h1000_0020, 1'b1);
        cyc();
        cyc();
        chk("lock_idle_hold", HMASTER, 1'b0);
        set_m(0, 2'b10, 32'h1000_0030, 1'b0);
        cyc();
        chk("unlock_busy_hold", HMASTER, 1'b0);
        set_m(0, 2'b00, 32'h1000_0030, 1'b0);
        cyc();
        chk("unlock_idle_sw", HMASTER, 1'b1);
        chk("unlock_idle_HADDR", bus_if.HADDR, 32'h4030_0010);

        // 5. parking: 4 idle cycles, M1 restarts the count, then 8 idle cycles
        set_m(1, 2'b00, 32'h4030_0010, 1'b0);
        for (int i = 0; i < 4; i++) cyc();
        chk("park_pre_restart", HMASTER, 1'b1);
        set_m(1, 2'b10, 32'h4030_0020, 1'b0);
        cyc();
        set_m(1, 2'b00, 32'h4030_0020, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            cyc();
            chk("park_not_yet", HMASTER, 1'b1);
        end
        cyc();
        chk("park_done", HMASTER, 1'b0);

        // error response passes to the owner only
        set_m(0, 2'b10, 32'h1000_0040, 1'b0);
        cyc();
        set_m(0, 2'b00, 32'h1000_0040, 1'b0);
        bus_if.HREADY = 1'b0;
        bus_if.HRESP  = 1'b1;
        #1;
        chk("err_M0_HRESP",  m0_if.HRESP, 1'b1);
        chk("err_M1_HRESP",  m1_if.HRESP, 1'b0);
        chk("err_M0_HREADY", m0_if.HREADY, 1'b0);
        cyc();
        bus_if.HREADY = 1'b1;
        cyc();
        bus_if.HRESP  = 1'b0;
        cyc();

        // 6. starvation: M0 streams NONSEQ for 64 cycles with M1 waiting
        set_m(1, 2'b10, 32'h4030_0030, 1'b0);
        for (int k = 1; k <= 64; k++) begin
            set_m(0, 2'b10, 32'h1000_1000 + 32'(k * 4), 1'b0);
            cyc();
            if (k == 63) chk("starve_63", ARB_STARVE, 1'b0);
            if (k == 64) chk("starve_64", ARB_STARVE, 1'b1);
        end
        set_m(0, 2'b00, 32'h1000_2000, 1'b0);
        cyc();
        chk("starve_clr_HMASTER", HMASTER, 1'b1);
        chk("starve_clr_flag",    ARB_STARVE, 1'b0);

        // reset in the middle of an M1 transfer
        set_m(1, 2'b10, 32'h4030_0040, 1'b0);
        cyc();
        HRESETn = 1'b0;
        cyc();
        chk("midrst_HMASTER", HMASTER, 1'b0);
        chk("midrst_HADDR",   bus_if.HADDR, 32'h1000_2000);
        HRESETn = 1'b1;
        set_m(1, 2'b00, 32'h4030_0040, 1'b0);
        cyc();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
